// File: rtl/dnn_pkg.sv
// ============================================================================
//  Module      : dnn_pkg
//  Description : Shared constants, state encoding and helpers for the DNN
//                output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dnn_pkg;

    localparam int WEIGHT_W = 5;
    localparam int N_HIDDEN = 4;
    localparam int N_OUT    = 2;
    // One counter value per (neuron, hidden input) product.
    localparam int CNT_W    = $clog2(N_HIDDEN * N_OUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MAC  = 1'b1
    } out_state_t;

    // Rectified linear unit on a sign-extended value; callers truncate back
    // to their own width, which is lossless because the result is >= 0.
    function automatic logic signed [31:0] relu(input logic signed [31:0] v);
        return (v < 0) ? 32'sd0 : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_unit.sv
// ============================================================================
//  Module      : mac_unit
//  Description : Signed multiply-accumulate with synchronous clear and
//                enable. sum_o exposes acc + a*b so the caller can capture a
//                finished dot product on the same edge that clears it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_unit #(
    parameter int A_W   = 12,
    parameter int B_W   = 5,
    parameter int ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [A_W+B_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   acc_q;

    // Full-precision product, sign-extended into the accumulator width.
    assign w_prod = a_i * b_i;
    assign sum_o  = acc_q + ACC_W'(w_prod);

    // Clear has priority so the last term of one neuron never leaks into
    // the next neuron's sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/output_layer_seq.sv
// ============================================================================
//  Module      : output_layer_seq
//  Description : DNN output layer. ReLU on four hidden results, then two
//                output neurons computed serially on one shared MAC.
//                Result valid flagged by a one-cycle output_ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_layer_seq
    import dnn_pkg::*;
#(
    parameter int input_width  = 12,
    parameter int output_width = 19
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           input_ready,
    input  logic signed [input_width-1:0]  in0,
    input  logic signed [input_width-1:0]  in1,
    input  logic signed [input_width-1:0]  in2,
    input  logic signed [input_width-1:0]  in3,
    input  logic signed [WEIGHT_W-1:0]     w48,
    input  logic signed [WEIGHT_W-1:0]     w58,
    input  logic signed [WEIGHT_W-1:0]     w68,
    input  logic signed [WEIGHT_W-1:0]     w78,
    input  logic signed [WEIGHT_W-1:0]     w49,
    input  logic signed [WEIGHT_W-1:0]     w59,
    input  logic signed [WEIGHT_W-1:0]     w69,
    input  logic signed [WEIGHT_W-1:0]     w79,
    output logic signed [output_width-1:0] out0,
    output logic signed [output_width-1:0] out1,
    output logic                           output_ready
);

    // Counter values at which the first and second neuron sums are complete.
    localparam logic [CNT_W-1:0] c_LAST_N8 = CNT_W'(N_HIDDEN - 1);
    localparam logic [CNT_W-1:0] c_LAST_N9 = CNT_W'(N_HIDDEN * N_OUT - 1);

    out_state_t                    state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic                          input_ready_q;
    logic signed [input_width-1:0] x_q [N_HIDDEN];

    logic signed [input_width-1:0] w_in  [N_HIDDEN];
    logic signed [input_width-1:0] x_d   [N_HIDDEN];
    logic signed [WEIGHT_W-1:0]    w_wt  [N_OUT][N_HIDDEN];
    logic signed [input_width-1:0] w_a;
    logic signed [WEIGHT_W-1:0]    w_b;
    logic signed [output_width-1:0] w_sum;
    logic                          w_start;
    logic                          w_clr;
    logic                          w_en;

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;

    // Row = output neuron (cnt MSB), column = hidden input (cnt LSBs).
    assign w_wt[0][0] = w48;
    assign w_wt[0][1] = w58;
    assign w_wt[0][2] = w68;
    assign w_wt[0][3] = w78;
    assign w_wt[1][0] = w49;
    assign w_wt[1][1] = w59;
    assign w_wt[1][2] = w69;
    assign w_wt[1][3] = w79;

    generate
        for (genvar g = 0; g < N_HIDDEN; g++) begin : g_relu
            assign x_d[g] = input_width'(relu(32'(w_in[g])));
        end
    endgenerate

    // Rising edge of the level-valid input; a held level starts only once.
    assign w_start = input_ready & ~input_ready_q;

    // Operand select for the current MAC step.
    assign w_a = x_q[cnt_q[CNT_W-2:0]];
    assign w_b = w_wt[cnt_q[CNT_W-1]][cnt_q[CNT_W-2:0]];

    // Clear on accepted start and after the first neuron's last term.
    assign w_clr = ((state_q == IDLE) && w_start) ||
                   ((state_q == MAC)  && (cnt_q == c_LAST_N8));
    assign w_en  = (state_q == MAC);

    mac_unit #(
        .A_W   (input_width),
        .B_W   (WEIGHT_W),
        .ACC_W (output_width)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_clr),
        .en_i  (w_en),
        .a_i   (w_a),
        .b_i   (w_b),
        .sum_o (w_sum)
    );

    // Sequencer: edge detect, operand capture, step counter, result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            input_ready_q <= 1'b0;
            out0          <= '0;
            out1          <= '0;
            output_ready  <= 1'b0;
            for (int k = 0; k < N_HIDDEN; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            input_ready_q <= input_ready;
            output_ready  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_start) begin
                        for (int k = 0; k < N_HIDDEN; k++) begin
                            x_q[k] <= x_d[k];
                        end
                        cnt_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == c_LAST_N8) begin
                        out0 <= w_sum;
                    end
                    if (cnt_q == c_LAST_N9) begin
                        out1         <= w_sum;
                        output_ready <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_output_layer_seq.sv
// ============================================================================
//  Module      : tb_output_layer_seq
//  Description : Self-checking bench for output_layer_seq against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_layer_seq;

    localparam int IW = 12;
    localparam int OW = 19;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 input_ready = 1'b0;
    logic signed [IW-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic signed [4:0]    w48 = '0, w58 = '0, w68 = '0, w78 = '0;
    logic signed [4:0]    w49 = '0, w59 = '0, w69 = '0, w79 = '0;
    logic signed [OW-1:0] out0, out1;
    logic                 output_ready;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int rdy_cnt = 0;

    always #5 clk = ~clk;

    output_layer_seq #(
        .input_width  (IW),
        .output_width (OW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_ready  (input_ready),
        .in0          (in0),
        .in1          (in1),
        .in2          (in2),
        .in3          (in3),
        .w48          (w48),
        .w58          (w58),
        .w68          (w68),
        .w78          (w78),
        .w49          (w49),
        .w59          (w59),
        .w69          (w69),
        .w79          (w79),
        .out0         (out0),
        .out1         (out1),
        .output_ready (output_ready)
    );

    // ---------------- reference model ----------------
    function automatic int relu_i(int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int dot(int a0, int a1, int a2, int a3,
                               int b0, int b1, int b2, int b3);
        return relu_i(a0) * b0 + relu_i(a1) * b1 + relu_i(a2) * b2 + relu_i(a3) * b3;
    endfunction

    int m_out0, m_out1, m_p0, m_p1, m_done;
    bit m_ready, m_busy, m_ir_prev;

    // Transaction view: a rising input_ready seen while not busy captures the
    // operands; neuron 8 appears 4 edges later, neuron 9 + ready after 8.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out0 <= 0; m_out1 <= 0; m_ready <= 1'b0;
            m_busy <= 1'b0; m_done <= 0; m_ir_prev <= 1'b0;
            m_p0 <= 0; m_p1 <= 0;
        end else begin
            m_ready   <= 1'b0;
            m_ir_prev <= input_ready;
            if (m_busy) begin
                m_done <= m_done + 1;
                if (m_done == 3) m_out0 <= m_p0;
                if (m_done == 7) begin
                    m_out1  <= m_p1;
                    m_ready <= 1'b1;
                    m_busy  <= 1'b0;
                end
            end else if (input_ready && !m_ir_prev) begin
                m_p0   <= dot(int'(in0), int'(in1), int'(in2), int'(in3),
                              int'(w48), int'(w58), int'(w68), int'(w78));
                m_p1   <= dot(int'(in0), int'(in1), int'(in2), int'(in3),
                              int'(w49), int'(w59), int'(w69), int'(w79));
                m_busy <= 1'b1;
                m_done <= 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out0", int'(out0), m_out0);
            check("cyc_out1", int'(out1), m_out1);
            check("cyc_ready", int'(output_ready), int'(m_ready));
        end
    end

    always @(negedge clk) begin
        if (output_ready) rdy_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input int a, input int b, input int c, input int d);
        in0 = IW'(a); in1 = IW'(b); in2 = IW'(c); in3 = IW'(d);
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d,
                         input int e, input int f, input int g, input int h);
        w48 = 5'(a); w58 = 5'(b); w68 = 5'(c); w78 = 5'(d);
        w49 = 5'(e); w59 = 5'(f); w69 = 5'(g); w79 = 5'(h);
    endtask

    task automatic pulse();
        @(negedge clk);
        input_ready = 1'b1;
        @(negedge clk);
        input_ready = 1'b0;
    endtask

    // Returns the number of falling edges waited; flags a timeout as a failure.
    task automatic wait_ready(output int cycles);
        cycles = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (output_ready) begin
                cycles = i + 1;
                break;
            end
        end
        total++;
        if (cycles < 0) begin
            bad++;
            $display("FAIL wait_ready actual=timeout required=output_ready");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int base;
        repeat (3) @(negedge clk);
        check("rst_out0", int'(out0), 0);
        check("rst_out1", int'(out1), 0);
        check("rst_ready", int'(output_ready), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic case, latency and single-cycle pulse.
        set_in(1, 2, 3, 4);
        set_w(1, 1, 1, 1, 1, 1, 1, 1);
        pulse();
        wait_ready(n);
        check("latency", n, 8);
        check("t1_out0", int'(out0), 10);
        check("t1_out1", int'(out1), 10);
        @(negedge clk);
        check("t1_pulse_width", int'(output_ready), 0);

        // ReLU zeroes negative inputs.
        set_in(-5, 100, -1, 7);
        set_w(2, -3, 15, 1, -16, -16, -16, -16);
        pulse();
        wait_ready(n);
        check("t2_out0", int'(out0), -293);
        check("t2_out1", int'(out1), -1712);

        // Extremes: no wrap, then all-negative inputs vanish.
        set_in(2047, 2047, 2047, 2047);
        set_w(-16, -16, -16, -16, -16, -16, -16, -16);
        pulse();
        wait_ready(n);
        check("t3_out0", int'(out0), -131008);
        check("t3_out1", int'(out1), -131008);
        set_in(-2048, -2048, -2048, -2048);
        pulse();
        wait_ready(n);
        check("t3_neg_out0", int'(out0), 0);
        check("t3_neg_out1", int'(out1), 0);

        // Held level produces exactly one computation.
        set_in(1, 2, 3, 4);
        set_w(1, 1, 1, 1, 1, 1, 1, 1);
        #1 base = rdy_cnt;
        @(negedge clk);
        input_ready = 1'b1;
        repeat (30) @(negedge clk);
        input_ready = 1'b0;
        repeat (12) @(negedge clk);
        #1 check("hold_one_run", rdy_cnt - base, 1);
        check("hold_out0", int'(out0), 10);

        // Pulse mid-MAC is dropped; input changes in flight are ignored.
        pulse();
        repeat (2) @(negedge clk);
        set_in(50, 50, 50, 50);
        input_ready = 1'b1;
        @(negedge clk);
        input_ready = 1'b0;
        wait_ready(n);
        check("drop_out0", int'(out0), 10);
        check("drop_out1", int'(out1), 10);
        // Start sampled at E9 is accepted.
        set_in(5, 6, 7, 8);
        input_ready = 1'b1;
        @(negedge clk);
        input_ready = 1'b0;
        wait_ready(n);
        check("e9_out0", int'(out0), 26);
        check("e9_out1", int'(out1), 26);

        // Asynchronous reset in the middle of a run.
        set_in(9, 9, 9, 9);
        pulse();
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out0", int'(out0), 0);
        check("arst_out1", int'(out1), 0);
        check("arst_ready", int'(output_ready), 0);
        check("arst_idle", int'(dut.state_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 2, 3, 4);
        pulse();
        wait_ready(n);
        check("post_rst_out0", int'(out0), 10);
        check("post_rst_out1", int'(out1), 10);

        // Randomized runs with in-flight disturbances.
        for (int it = 0; it < 60; it++) begin
            int len;
            set_in(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            set_w(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            input_ready = 1'b1;
            len = int'($urandom_range(1, 3));
            repeat (len) @(negedge clk);
            input_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            set_in(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            if ($urandom_range(0, 1) == 1) begin
                input_ready = 1'b1;
                @(negedge clk);
                input_ready = 1'b0;
            end
            wait_ready(n);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
